// File: rtl/reaction_timer_pkg.sv
// Shared state encodings, LFSR constants and BCD helpers for the reaction timer.
package reaction_timer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_DELAY = 3'd1;
  localparam logic [STATE_W-1:0] ST_RUN   = 3'd2;
  localparam logic [STATE_W-1:0] ST_SHOW  = 3'd3;
  localparam logic [STATE_W-1:0] ST_CHEAT = 3'd4;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0
  localparam int unsigned        LFSR_W    = 16;
  localparam logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400;

  localparam int unsigned DELAY_W    = 13;
  localparam int unsigned DELAY_BASE = 1000;
  localparam int unsigned BCD_MAX    = 9999;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
  } bcd_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic bcd_t to_bcd(input int unsigned v);
    bcd_t b;
    b.d0 = 4'(v % 10);
    b.d1 = 4'((v / 10) % 10);
    b.d2 = 4'((v / 100) % 10);
    b.d3 = 4'((v / 1000) % 10);
    return b;
  endfunction

  localparam bcd_t BCD_MAX_VAL = to_bcd(BCD_MAX);

  // Decimal increment with ripple carry; 9999 wraps to 0000 (callers saturate first).
  function automatic bcd_t bcd_inc(input bcd_t b);
    bcd_t r;
    r = b;
    if (b.d0 != 4'd9) begin
      r.d0 = b.d0 + 4'd1;
    end else begin
      r.d0 = 4'd0;
      if (b.d1 != 4'd9) begin
        r.d1 = b.d1 + 4'd1;
      end else begin
        r.d1 = 4'd0;
        if (b.d2 != 4'd9) begin
          r.d2 = b.d2 + 4'd1;
        end else begin
          r.d2 = 4'd0;
          r.d3 = (b.d3 == 4'd9) ? 4'd0 : b.d3 + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_DIV enabled cycles.
module ms_tick_gen #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign tick   = enable && w_wrap;

  // Counter idles at zero whenever the timer is not waiting or timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || !enable || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer: random 1.0-5.1 s wait, then ms-resolution BCD timing of the player's press.
module reaction_timer_ctrl
  import reaction_timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       react,
  output logic       go_led,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic       cheat,
  output logic       overflow
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [DELAY_W-1:0] r_delay;
  logic [DELAY_W-1:0] w_delay_nxt;
  bcd_t               r_digits;
  bcd_t               w_digits_nxt;
  logic               r_go;
  logic               w_go_nxt;
  logic               r_cheat;
  logic               w_cheat_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               w_tick;
  logic               w_tick_en;
  logic               w_tick_clr;

  assign w_tick_en = (r_state == ST_DELAY) || (r_state == ST_RUN);

  ms_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (w_tick_clr),
    .enable(w_tick_en),
    .tick  (w_tick)
  );

  // Free-running random source; sampled only when a trial starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_delay_nxt  = r_delay;
    w_digits_nxt = r_digits;
    w_go_nxt     = r_go;
    w_cheat_nxt  = r_cheat;
    w_ovf_nxt    = r_ovf;
    w_tick_clr   = 1'b0;
    case (r_state)
      ST_IDLE, ST_SHOW, ST_CHEAT: begin
        if (start) begin
          w_state_nxt  = ST_DELAY;
          w_digits_nxt = '0;
          w_cheat_nxt  = 1'b0;
          w_ovf_nxt    = 1'b0;
          w_delay_nxt  = DELAY_W'(DELAY_BASE) + DELAY_W'(r_lfsr[11:0]);
          w_tick_clr   = 1'b1;
        end
      end
      ST_DELAY: begin
        // An early press beats a terminal tick arriving in the same cycle.
        if (react) begin
          w_state_nxt  = ST_CHEAT;
          w_cheat_nxt  = 1'b1;
          w_go_nxt     = 1'b0;
          w_digits_nxt = '0;
        end else if (w_tick) begin
          if (r_delay <= DELAY_W'(1)) begin
            w_state_nxt = ST_RUN;
            w_go_nxt    = 1'b1;
            w_tick_clr  = 1'b1;
          end else begin
            w_delay_nxt = r_delay - DELAY_W'(1);
          end
        end
      end
      ST_RUN: begin
        // A press freezes the count; a coincident tick is not counted.
        if (react) begin
          w_state_nxt = ST_SHOW;
          w_go_nxt    = 1'b0;
        end else if (w_tick) begin
          if (r_digits == BCD_MAX_VAL) begin
            w_state_nxt = ST_SHOW;
            w_go_nxt    = 1'b0;
            w_ovf_nxt   = 1'b1;
          end else begin
            w_digits_nxt = bcd_inc(r_digits);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_go_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_delay  <= '0;
      r_digits <= '0;
      r_go     <= 1'b0;
      r_cheat  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_delay  <= w_delay_nxt;
      r_digits <= w_digits_nxt;
      r_go     <= w_go_nxt;
      r_cheat  <= w_cheat_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign go_led   = r_go;
  assign cheat    = r_cheat;
  assign overflow = r_ovf;
  assign bcd0     = r_digits.d0;
  assign bcd1     = r_digits.d1;
  assign bcd2     = r_digits.d2;
  assign bcd3     = r_digits.d3;

endmodule
